spi_slave_frame: RTL and testbench

- Parametrised SPI slave front-end for the single-port RAM path. Successor to the fixed 10-bit SPI slave.
- Deserialises MOSI frames of CMD_W+PAYLOAD_W bits into rx_data with a one-cycle rx_valid strobe.
- For read-data commands, waits for tx_valid and then serialises DATA_W bits of tx_data on MISO.
- Adds configurable widths, bit order, explicit command decode, frame-abort detection and read-sequencing checks.

---
 rtl/spi_slave_pkg.sv | 20 ++
 rtl/spi_shift_out.sv | 43 ++++
 rtl/spi_slave_frame.sv | 119 +++++++++++
 tb/tb_spi_slave_frame.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared encodings for the SPI slave frame front-end.
// FSM states and the 2-bit command field.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ,
    RD_WAIT,
    SHIFT_OUT,
    DONE
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shift_out.sv
// MISO serialiser: parallel load, bit-order select, done flag.
// The first bit is presented in the cycle right after load.
module spi_shift_out #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] data,
  output logic              bit_out,
  output logic              done
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sreg;
  logic [CW-1:0]     cnt;

  assign done = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg    <= '0;
      cnt     <= '0;
      bit_out <= 1'b0;
    end else if (load) begin
      bit_out <= LSB_FIRST ? data[0] : data[DATA_W-1];
      sreg    <= LSB_FIRST ? data >> 1 : data << 1;
      cnt     <= CW'(DATA_W - 1);
    end else if (shift && !done) begin
      bit_out <= LSB_FIRST ? sreg[0] : sreg[DATA_W-1];
      sreg    <= LSB_FIRST ? sreg >> 1 : sreg << 1;
      cnt     <= cnt - CW'(1);
    end else begin
      // idle line is low whenever nothing is being shifted
      bit_out <= 1'b0;
      cnt     <= '0;
    end
  end

endmodule

// File: rtl/spi_slave_frame.sv
// SPI slave frame front-end: MOSI deserialiser, command FSM,
// read sequencing check and MISO read-data path.
module spi_slave_frame
  import spi_slave_pkg::*;
#(
  parameter int PAYLOAD_W = 8,
  parameter int CMD_W     = 2,
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       SS_n,
  input  logic                       MOSI,
  output logic                       MISO,
  output logic [CMD_W+PAYLOAD_W-1:0] rx_data,
  output logic                       rx_valid,
  input  logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_valid,
  output logic                       frame_err
);

  localparam int FW   = CMD_W + PAYLOAD_W;
  localparam int MAXW = (FW > DATA_W) ? FW : DATA_W;
  localparam int CW   = $clog2(MAXW + 1);

  state_t          state;
  state_t          next;
  logic [CW-1:0]   cnt;
  logic [FW-1:0]   shreg;
  logic [FW-1:0]   frame;
  logic [1:0]      cmd;
  logic            rd_seen;
  logic            active;
  logic            frame_end;
  logic            abort;
  logic            rd_err;
  logic            load;
  logic            shift;
  logic            so_done;

  always_comb begin
    frame     = LSB_FIRST ? {MOSI, shreg[FW-1:1]}
                          : {shreg[FW-2:0], MOSI};
    cmd       = frame[FW-1 -: 2];
    active    = (state == WRITE) || (state == READ);
    frame_end = active && !SS_n && (cnt == CW'(FW - 1));
    abort     = SS_n && (active || state == RD_WAIT
                         || state == SHIFT_OUT);
    rd_err    = frame_end && (cmd == CMD_RD_DATA) && !rd_seen;
    load      = (state == RD_WAIT) && !SS_n && tx_valid;
    shift     = (state == SHIFT_OUT) && !SS_n;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:      if (!SS_n) next = CHK_CMD;
      CHK_CMD:   next = SS_n ? IDLE : (MOSI ? READ : WRITE);
      WRITE,
      READ: begin
        if (SS_n) next = IDLE;
        else if (frame_end)
          next = (cmd == CMD_RD_DATA && rd_seen) ? RD_WAIT : DONE;
      end
      RD_WAIT: begin
        if (SS_n) next = IDLE;
        else if (tx_valid) next = SHIFT_OUT;
      end
      SHIFT_OUT: begin
        if (SS_n) next = IDLE;
        else if (so_done) next = DONE;
      end
      DONE:      if (SS_n) next = IDLE;
      default:   next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rd_seen   <= 1'b0;
    end else begin
      rx_valid  <= frame_end;
      frame_err <= abort || rd_err;
      cnt <= (next == WRITE || next == READ) ? cnt + CW'(1) : '0;
      if (!SS_n && (state == CHK_CMD || active)) shreg <= frame;
      // aborted frames never reach here, so rd_seen survives them
      if (frame_end) begin
        rx_data <= frame;
        if (cmd == CMD_RD_ADDR)      rd_seen <= 1'b1;
        else if (cmd == CMD_RD_DATA) rd_seen <= 1'b0;
      end
    end
  end

  spi_shift_out #(
    .DATA_W    (DATA_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .shift   (shift),
    .data    (tx_data),
    .bit_out (MISO),
    .done    (so_done)
  );

endmodule

// File: tb/tb_spi_slave_frame.sv
// Directed bench: MSB-first, LSB-first and wide-frame instances.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_spi_slave_frame;

  logic        clk;
  logic        rst_n;
  logic [2:0]  ss_n;
  logic [2:0]  mosi;
  logic [2:0]  tx_valid;
  logic [15:0] txd [3];
  wire  [2:0]  miso;
  wire  [2:0]  rx_valid;
  wire  [2:0]  frame_err;
  wire  [9:0]  rx0;
  wire  [9:0]  rx1;
  wire  [11:0] rx2;

  int tests = 0;
  int fails = 0;
  int rxv_cnt [3];
  int fe_cnt  [3];
  int mhi_cnt [3];

  spi_slave_frame u0 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[0]), .MOSI(mosi[0]),
    .MISO(miso[0]), .rx_data(rx0), .rx_valid(rx_valid[0]),
    .tx_data(txd[0][7:0]), .tx_valid(tx_valid[0]),
    .frame_err(frame_err[0])
  );

  spi_slave_frame #(.LSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[1]), .MOSI(mosi[1]),
    .MISO(miso[1]), .rx_data(rx1), .rx_valid(rx_valid[1]),
    .tx_data(txd[1][7:0]), .tx_valid(tx_valid[1]),
    .frame_err(frame_err[1])
  );

  spi_slave_frame #(.PAYLOAD_W(10), .DATA_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[2]), .MOSI(mosi[2]),
    .MISO(miso[2]), .rx_data(rx2), .rx_valid(rx_valid[2]),
    .tx_data(txd[2]), .tx_valid(tx_valid[2]),
    .frame_err(frame_err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      rxv_cnt[d] <= rxv_cnt[d] + int'(rx_valid[d]);
      fe_cnt[d]  <= fe_cnt[d] + int'(frame_err[d]);
      mhi_cnt[d] <= mhi_cnt[d] + int'(miso[d]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int d, input logic [15:0] f,
                      input int fw, input bit lsb);
    @(negedge clk) ss_n[d] = 1'b0;
    for (int i = 0; i < fw; i++) begin
      @(negedge clk);
      mosi[d] = lsb ? f[i] : f[fw-1-i];
    end
    @(negedge clk);
    mosi[d] = 1'b0;
  endtask

  task automatic close(input int d);
    @(negedge clk) ss_n[d] = 1'b1;
  endtask

  initial begin
    logic [15:0] bits;
    int r0, f0, m0;

    rst_n = 1'b0;
    ss_n = 3'b111;
    mosi = 3'b000;
    tx_valid = 3'b000;
    for (int d = 0; d < 3; d++) txd[d] = '0;
    tick();
    tick();
    chk("rst_rx_data", 32'(rx0), 32'h0);
    chk("rst_rx_valid", 32'(rx_valid[0]), 32'h0);
    chk("rst_frame_err", 32'(frame_err[0]), 32'h0);
    chk("rst_miso", 32'(miso[0]), 32'h0);
    rst_n = 1'b1;
    tick();

    // write-address frame
    r0 = rxv_cnt[0]; f0 = fe_cnt[0]; m0 = mhi_cnt[0];
    send(0, 16'h0A5, 10, 1'b0);
    chk("wa_rx_valid", 32'(rx_valid[0]), 32'h1);
    chk("wa_rx_data", 32'(rx0), 32'h0A5);
    chk("wa_frame_err", 32'(frame_err[0]), 32'h0);
    tick();
    chk("wa_rx_valid_1cyc", 32'(rx_valid[0]), 32'h0);
    close(0);
    tick();
    chk("wa_pulses", 32'(rxv_cnt[0] - r0), 32'h1);
    chk("wa_no_err", 32'(fe_cnt[0] - f0), 32'h0);
    chk("wa_miso_low", 32'(mhi_cnt[0] - m0), 32'h0);

    // rd-addr then rd-data, MSB-first read of C3
    r0 = rxv_cnt[0]; f0 = fe_cnt[0];
    send(0, 16'h203, 10, 1'b0);
    close(0);
    send(0, 16'h300, 10, 1'b0);
    chk("rd_rx_data", 32'(rx0), 32'h300);
    tick();
    tick();
    txd[0] = 16'h00C3;
    tx_valid[0] = 1'b1;
    tick();
    tx_valid[0] = 1'b0;
    bits = '0;
    for (int i = 0; i < 8; i++) begin
      bits = {bits[14:0], miso[0]};
      tick();
    end
    chk("rd_miso_seq", 32'(bits), 32'h00C3);
    chk("rd_miso_done", 32'(miso[0]), 32'h0);
    close(0);
    tick();
    chk("rd_pulses", 32'(rxv_cnt[0] - r0), 32'h2);
    chk("rd_no_err", 32'(fe_cnt[0] - f0), 32'h0);

    // LSB-first instance: 1D goes out as 1,0,1,1,1,0,0,0
    send(1, 16'h203, 10, 1'b1);
    chk("lsb_ra_rx_data", 32'(rx1), 32'h203);
    close(1);
    send(1, 16'h300, 10, 1'b1);
    chk("lsb_rd_rx_data", 32'(rx1), 32'h300);
    txd[1] = 16'h001D;
    tx_valid[1] = 1'b1;
    tick();
    tx_valid[1] = 1'b0;
    bits = '0;
    for (int i = 0; i < 8; i++) begin
      bits = {bits[14:0], miso[1]};
      tick();
    end
    chk("lsb_miso_seq", 32'(bits), 32'h00B8);
    chk("lsb_err", 32'(fe_cnt[1]), 32'h0);
    close(1);
    tick();

    // rd-data without preceding rd-addr
    f0 = fe_cnt[0]; m0 = mhi_cnt[0];
    send(0, 16'h3FF, 10, 1'b0);
    chk("nra_rx_valid", 32'(rx_valid[0]), 32'h1);
    chk("nra_frame_err", 32'(frame_err[0]), 32'h1);
    tick();
    txd[0] = 16'h00FF;
    tx_valid[0] = 1'b1;
    tick();
    tick();
    chk("nra_miso", 32'(miso[0]), 32'h0);
    tx_valid[0] = 1'b0;
    close(0);
    tick();
    chk("nra_err_once", 32'(fe_cnt[0] - f0), 32'h1);
    chk("nra_miso_low", 32'(mhi_cnt[0] - m0), 32'h0);

    // abort after 6 bits of a write frame
    r0 = rxv_cnt[0];
    @(negedge clk) ss_n[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mosi[0] = (i % 2 == 1);
    end
    @(negedge clk) ss_n[0] = 1'b1;
    tick();
    chk("ab_frame_err", 32'(frame_err[0]), 32'h1);
    chk("ab_rx_hold", 32'(rx0), 32'h3FF);
    tick();
    chk("ab_err_1cyc", 32'(frame_err[0]), 32'h0);
    chk("ab_no_rx_valid", 32'(rxv_cnt[0] - r0), 32'h0);
    send(0, 16'h155, 10, 1'b0);
    chk("ab_next_valid", 32'(rx_valid[0]), 32'h1);
    chk("ab_next_data", 32'(rx0), 32'h155);
    close(0);

    // reset during SHIFT_OUT, then rd-data needs a new rd-addr
    send(0, 16'h203, 10, 1'b0);
    close(0);
    send(0, 16'h300, 10, 1'b0);
    txd[0] = 16'h00FF;
    tx_valid[0] = 1'b1;
    tick();
    tx_valid[0] = 1'b0;
    chk("rs_miso_bit", 32'(miso[0]), 32'h1);
    tick();
    rst_n = 1'b0;
    ss_n[0] = 1'b1;
    tick();
    chk("rs_miso", 32'(miso[0]), 32'h0);
    chk("rs_rx_valid", 32'(rx_valid[0]), 32'h0);
    chk("rs_frame_err", 32'(frame_err[0]), 32'h0);
    chk("rs_rx_data", 32'(rx0), 32'h0);
    rst_n = 1'b1;
    tick();
    send(0, 16'h300, 10, 1'b0);
    chk("rs_nra_err", 32'(frame_err[0]), 32'h1);
    close(0);

    // 12-bit frame, 16-bit read
    send(2, 16'h7F0, 12, 1'b0);
    chk("w_rx_valid", 32'(rx_valid[2]), 32'h1);
    chk("w_rx_data", 32'(rx2), 32'h7F0);
    close(2);
    send(2, 16'h805, 12, 1'b0);
    close(2);
    send(2, 16'hC00, 12, 1'b0);
    chk("w_rd_rx_data", 32'(rx2), 32'hC00);
    txd[2] = 16'hBEEF;
    tx_valid[2] = 1'b1;
    tick();
    tx_valid[2] = 1'b0;
    bits = '0;
    for (int i = 0; i < 16; i++) begin
      bits = {bits[14:0], miso[2]};
      tick();
    end
    chk("w_miso_seq", 32'(bits), 32'hBEEF);
    chk("w_miso_done", 32'(miso[2]), 32'h0);
    chk("w_err", 32'(fe_cnt[2]), 32'h0);
    close(2);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
